ret_fsm: RTL and testbench

//  Return-sequence controller; counterpart of the CALL push sequencer. On RET it stalls fetch and injects two POP

---
 rtl/cpu_pkg.sv | 32 +++
 rtl/ret_pc_assembler.sv | 69 ++++++
 rtl/ret_fsm.sv | 135 +++++++++++++
 tb/tb_ret_fsm.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// ============================================================================
// Package : cpu_pkg
// Purpose : Opcode constants shared by call_fsm, ret_fsm and decode. Also
//           holds the return-sequencer state type ret_state_t.
// Config  : RTI_FLAGS_EN adds POP_FLAGS_OP and the ST_POP_FL state.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

    localparam logic [15:0] POP_PC_HIGH_OP = 16'b0111000000001001;
    localparam logic [15:0] POP_PC_LOW_OP  = 16'b0111000000001000;
    localparam logic [15:0] NOP_OP         = 16'h0000;
`ifdef RTI_FLAGS_EN
    localparam logic [15:0] POP_FLAGS_OP   = 16'b0111000000001010;
`endif

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
`ifdef RTI_FLAGS_EN
        ST_POP_FL   = 3'd1,
`endif
        ST_POP_HI   = 3'd2,
        ST_POP_LO   = 3'd3,
        ST_WAIT     = 3'd4,
        ST_REDIRECT = 3'd5
    } ret_state_t;

endpackage

`default_nettype wire

// File: rtl/ret_pc_assembler.sv
// ============================================================================
// Module  : ret_pc_assembler
// Purpose : Collects the words popped off the stack during a return sequence.
//           A saturating counter steers each accepted word into the flags,
//           hi or lo capture register; done rises once all words are in.
// Ports   : clk, reset (sync, active-low), clear (discard partial words),
//           capture_en (sequencer is in a collection state), mem_valid,
//           mem_rdata[15:0], with_flags (RTI only), hi/lo[15:0],
//           flags[15:0] (RTI only), done.
// Config  : RTI_FLAGS_EN adds the flags capture register and with_flags.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ret_pc_assembler
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        capture_en,
    input  logic        mem_valid,
    input  logic [15:0] mem_rdata,
`ifdef RTI_FLAGS_EN
    input  logic        with_flags,
    output logic [15:0] flags,
`endif
    output logic [15:0] hi,
    output logic [15:0] lo,
    output logic        done
);

    logic [1:0] count;
    logic [1:0] slot;

    // Slot numbering is fixed (0=flags, 1=hi, 2=lo); a plain RET starts at
    // slot 1 so the same decode serves both sequences.
`ifdef RTI_FLAGS_EN
    assign slot = with_flags ? count : count + 2'd1;
    assign done = (count == (with_flags ? 2'd3 : 2'd2));
`else
    assign slot = count + 2'd1;
    assign done = (count == 2'd2);
`endif

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            count <= 2'd0;
            hi    <= 16'h0000;
            lo    <= 16'h0000;
`ifdef RTI_FLAGS_EN
            flags <= 16'h0000;
`endif
        end else if (capture_en && mem_valid && !done) begin
            count <= count + 2'd1;
            case (slot)
`ifdef RTI_FLAGS_EN
                2'd0:    flags <= mem_rdata;
`endif
                2'd1:    hi    <= mem_rdata;
                2'd2:    lo    <= mem_rdata;
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/ret_fsm.sv
// ============================================================================
// Module  : ret_fsm
// Purpose : Return-sequence controller. On RET it stalls fetch, injects
//           POP micro-ops (PC high, then PC low) into decode, waits for the
//           popped words and issues a one-cycle fetch redirect to {hi,lo}.
// Ports   : clk, reset (sync, active-low), ret, rti, mem_valid,
//           mem_rdata[15:0], out[15:0], stall, pc_valid, pc[31:0],
//           flags[15:0] (RTI only).
// Config  : RTI_FLAGS_EN - ret&rti pops a flags word first and restores it
//           on the flags port at redirect. Undefined: rti is ignored.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ret_fsm
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        ret,
    input  logic        rti,
    input  logic        mem_valid,
    input  logic [15:0] mem_rdata,
    output logic [15:0] out,
    output logic        stall,
    output logic        pc_valid,
`ifdef RTI_FLAGS_EN
    output logic [15:0] flags,
`endif
    output logic [31:0] pc
);

    ret_state_t  state;
    ret_state_t  next_state;
    logic [15:0] next_out;
    logic        capture_en;
    logic        words_done;
    logic [15:0] word_hi;
    logic [15:0] word_lo;

`ifdef RTI_FLAGS_EN
    logic        rti_mode;
    logic [15:0] word_flags;
`else
    logic        unused_rti;
    assign unused_rti = rti;
`endif

    assign capture_en = (state != ST_IDLE) && (state != ST_REDIRECT);

    ret_pc_assembler u_asm (
        .clk        (clk),
        .reset      (reset),
        .clear      (state == ST_IDLE),
        .capture_en (capture_en),
        .mem_valid  (mem_valid),
        .mem_rdata  (mem_rdata),
`ifdef RTI_FLAGS_EN
        .with_flags (rti_mode),
        .flags      (word_flags),
`endif
        .hi         (word_hi),
        .lo         (word_lo),
        .done       (words_done)
    );

    // Next state; outputs are decoded from next_state so that they can be
    // registered and line up with the state they describe.
    always_comb begin
        next_state = state;
        next_out   = NOP_OP;
        case (state)
            ST_IDLE: begin
                if (ret) begin
`ifdef RTI_FLAGS_EN
                    next_state = rti ? ST_POP_FL : ST_POP_HI;
`else
                    next_state = ST_POP_HI;
`endif
                end
            end
`ifdef RTI_FLAGS_EN
            ST_POP_FL:   next_state = ST_POP_HI;
`endif
            ST_POP_HI:   next_state = ST_POP_LO;
            ST_POP_LO:   next_state = ST_WAIT;
            ST_WAIT:     if (words_done) next_state = ST_REDIRECT;
            ST_REDIRECT: next_state = ST_IDLE;
            default:     next_state = ST_IDLE;
        endcase

        case (next_state)
`ifdef RTI_FLAGS_EN
            ST_POP_FL: next_out = POP_FLAGS_OP;
`endif
            ST_POP_HI: next_out = POP_PC_HIGH_OP;
            ST_POP_LO: next_out = POP_PC_LOW_OP;
            default:   next_out = NOP_OP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= ST_IDLE;
            out      <= NOP_OP;
            stall    <= 1'b0;
            pc_valid <= 1'b0;
            pc       <= 32'h0000_0000;
`ifdef RTI_FLAGS_EN
            rti_mode <= 1'b0;
            flags    <= 16'h0000;
`endif
        end else begin
            state    <= next_state;
            out      <= next_out;
            stall    <= (next_state != ST_IDLE);
            pc_valid <= (next_state == ST_REDIRECT);
            // pc and flags only load on entry to REDIRECT and then hold.
            if (next_state == ST_REDIRECT) begin
                pc    <= {word_hi, word_lo};
`ifdef RTI_FLAGS_EN
                flags <= word_flags;
`endif
            end
`ifdef RTI_FLAGS_EN
            if (state == ST_IDLE && ret) begin
                rti_mode <= rti;
            end
`endif
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ret_fsm.sv
`default_nettype none

module tb_ret_fsm;

    logic        clk = 1'b0;
    logic        reset;
    logic        ret;
    logic        rti;
    logic        mem_valid;
    logic [15:0] mem_rdata;
    logic [15:0] out;
    logic        stall;
    logic        pc_valid;
    logic [31:0] pc;
`ifdef RTI_FLAGS_EN
    logic [15:0] flags;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ret_fsm dut (
        .clk       (clk),
        .reset     (reset),
        .ret       (ret),
        .rti       (rti),
        .mem_valid (mem_valid),
        .mem_rdata (mem_rdata),
        .out       (out),
        .stall     (stall),
        .pc_valid  (pc_valid),
`ifdef RTI_FLAGS_EN
        .flags     (flags),
`endif
        .pc        (pc)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic word(input logic v, input logic [15:0] d);
        mem_valid = v;
        mem_rdata = d;
    endtask

    // Step until pc_valid, with a cycle budget.
    task automatic wait_pc(input string tag, input int budget);
        int k = 0;
        while (!pc_valid && k < budget) begin
            step();
            k++;
        end
        check(tag, {31'd0, pc_valid}, 32'd1);
    endtask

    initial begin
        reset = 1'b0; ret = 1'b1; rti = 1'b0;
        word(1'b0, 16'h0000);

        // 1: reset beats ret
        step(); step();
        check("rst_out", {16'd0, out}, 32'h0000);
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_pcv", {31'd0, pc_valid}, 32'd0);
        check("rst_pc", pc, 32'h0);
        reset = 1'b1; ret = 1'b0;
        step();

        // 2: basic RET, zero-latency memory
        ret = 1'b1;
        step(); ret = 1'b0;
        check("b_out_hi", {16'd0, out}, 32'h7009);
        check("b_stall1", {31'd0, stall}, 32'd1);
        word(1'b1, 16'h0000);
        step();
        check("b_out_lo", {16'd0, out}, 32'h7008);
        word(1'b1, 16'h1234);
        step(); word(1'b0, 16'h0000);
        check("b_out_wait", {16'd0, out}, 32'h0000);
        check("b_pcv_wait", {31'd0, pc_valid}, 32'd0);
        step();
        check("b_pcv", {31'd0, pc_valid}, 32'd1);
        check("b_pc", pc, 32'h0000_1234);
        check("b_stall_redir", {31'd0, stall}, 32'd1);
        step();
        check("b_stall_drop", {31'd0, stall}, 32'd0);
        check("b_pcv_drop", {31'd0, pc_valid}, 32'd0);
        check("b_pc_hold", pc, 32'h0000_1234);

        // 3: slow memory, words 10 and 15 cycles after ret
        ret = 1'b1;
        step(); ret = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            if (k == 10) word(1'b1, 16'hABCD);
            else if (k == 15) word(1'b1, 16'h0042);
            else word(1'b0, 16'h0000);
            if (k == 5 || k == 12) begin
                check("s_stall", {31'd0, stall}, 32'd1);
                check("s_out_nop", {16'd0, out}, 32'h0000);
                check("s_pcv", {31'd0, pc_valid}, 32'd0);
            end
            step();
        end
        word(1'b0, 16'h0000);
        wait_pc("s_timeout", 4);
        check("s_pc", pc, 32'hABCD_0042);

        // 4: stray words in IDLE, extra word in WAIT, ret mid-sequence
        step();
        word(1'b1, 16'hDEAD);
        step(); step();
        ret = 1'b1;
        word(1'b1, 16'hBEEF);
        step(); ret = 1'b0;
        word(1'b1, 16'h5555);
        step();
        ret = 1'b1;
        word(1'b1, 16'h6666);
        step(); ret = 1'b0;
        word(1'b1, 16'h7777);
        wait_pc("x_timeout", 4);
        word(1'b0, 16'h0000);
        check("x_pc", pc, 32'h5555_6666);
        step(); step();
        check("x_no_queue_stall", {31'd0, stall}, 32'd0);
        check("x_no_queue_out", {16'd0, out}, 32'h0000);

        // 5: reset in WAIT after one word, then a clean RET
        ret = 1'b1;
        step(); ret = 1'b0;
        word(1'b1, 16'h1111);
        step(); word(1'b0, 16'h0000);
        step(); step();
        reset = 1'b0;
        step(); reset = 1'b1;
        check("r_stall", {31'd0, stall}, 32'd0);
        check("r_pcv", {31'd0, pc_valid}, 32'd0);
        check("r_pc", pc, 32'h0);
        for (int k = 0; k < 3; k++) begin
            step();
            check("r_no_pcv", {31'd0, pc_valid}, 32'd0);
        end
        ret = 1'b1;
        step(); ret = 1'b0;
        word(1'b1, 16'h2222);
        step();
        word(1'b1, 16'h3333);
        step(); word(1'b0, 16'h0000);
        wait_pc("r_timeout", 4);
        check("r_pc_clean", pc, 32'h2222_3333);
        step();

        // 6: RTI
        ret = 1'b1; rti = 1'b1;
        step(); ret = 1'b0; rti = 1'b0;
`ifdef RTI_FLAGS_EN
        check("f_out_fl", {16'd0, out}, 32'h700A);
        word(1'b1, 16'h0003);
        step();
        check("f_out_hi", {16'd0, out}, 32'h7009);
        word(1'b1, 16'h0000);
        step();
        check("f_out_lo", {16'd0, out}, 32'h7008);
        word(1'b1, 16'h0100);
        step(); word(1'b0, 16'h0000);
        wait_pc("f_timeout", 4);
        check("f_flags", {16'd0, flags}, 32'h0003);
        check("f_pc", pc, 32'h0000_0100);
`else
        check("f_rti_ignored", {16'd0, out}, 32'h7009);
        word(1'b1, 16'h0000);
        step();
        word(1'b1, 16'h0100);
        step(); word(1'b0, 16'h0000);
        wait_pc("f_timeout", 4);
        check("f_pc", pc, 32'h0000_0100);
`endif
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
